// File: rtl/addsub_btn_unit.sv
// Debounced two-button ALU: a clean btn1 press adds, a clean btn2 press subtracts, and the result is held until the next operation.
// Latency: valid pulses DB_CYCLES+3 edges after the raw press settles. There is no backpressure; presses made while busy are dropped.
module addsub_btn_unit #(
  parameter int WIDTH     = 8,
  parameter int DB_CYCLES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  input  logic             btn1,
  input  logic             btn2,
  output logic [WIDTH-1:0] S,
  output logic             C0,
  output logic             valid,
  output logic             err,
  output logic             busy
);
  localparam int CW = $clog2(DB_CYCLES + 1);
  localparam logic [CW-1:0] DB_LAST = CW'(DB_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, EXEC, HOLD} state_t;

  state_t              state, state_n;
  logic [1:0]          meta, sync_lvl, db, db_q, press;
  logic [1:0][CW-1:0]  db_cnt;
  logic [1:0]          boot_cnt;
  logic                boot_hold, boot_check;
  logic                do_exec, set_err;
  logic [WIDTH:0]      sum_w, diff_w;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta     <= '0;
      sync_lvl <= '0;
    end else begin
      meta     <= {btn2, btn1};
      sync_lvl <= meta;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      db     <= '0;
      db_q   <= '0;
      db_cnt <= '0;
    end else begin
      db_q <= db;
      for (int i = 0; i < 2; i++) begin
        if (sync_lvl[i] == db[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_LAST) begin
          db[i]     <= ~db[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + CW'(1);
        end
      end
    end
  end

  assign press = db & ~db_q;

  // The sync pipeline shows real button levels only from the third edge after reset;
  // a button already held at that point must be released before any press counts.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      boot_cnt  <= '0;
      boot_hold <= 1'b0;
    end else begin
      if (boot_cnt != 2'd3) boot_cnt <= boot_cnt + 2'd1;
      if (boot_check && (|sync_lvl)) boot_hold <= 1'b1;
      else if (~|sync_lvl)          boot_hold <= 1'b0;
    end
  end

  assign boot_check = (boot_cnt == 2'd2);

  always_comb begin
    state_n = state;
    do_exec = 1'b0;
    set_err = 1'b0;
    case (state)
      IDLE: begin
        if (boot_check && (|sync_lvl)) begin
          state_n = HOLD;
        end else if (boot_cnt[1]) begin
          if (&press) begin
            state_n = HOLD;
            set_err = 1'b1;
          end else if (|press) begin
            state_n = EXEC;
            do_exec = 1'b1;
          end
        end
      end
      EXEC:    state_n = HOLD;
      HOLD:    if (~|db && !boot_hold) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  assign sum_w  = {1'b0, A} + {1'b0, B} + {{WIDTH{1'b0}}, Cin};
  assign diff_w = {1'b0, A} - {1'b0, B} - {{WIDTH{1'b0}}, Cin};

  // The result is captured on the edge that enters EXEC, so valid coincides with the EXEC cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      S     <= '0;
      C0    <= 1'b0;
      valid <= 1'b0;
      err   <= 1'b0;
    end else begin
      state <= state_n;
      valid <= do_exec;
      if (do_exec) begin
        {C0, S} <= press[1] ? diff_w : sum_w;
        err     <= 1'b0;
      end else if (set_err) begin
        err <= 1'b1;
      end
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_addsub_btn_unit.sv
// Bench for addsub_btn_unit: two instances (8-bit/DB 4 and 2-bit/DB 1) checked each cycle
// against a history-based reference model, plus directed literal checks.
module tb_addsub_btn_unit;
  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [7:0] a0 = '0, b0 = '0;
  logic [1:0] a1 = '0, b1 = '0;
  logic       cin = 1'b0, btn1 = 1'b0, btn2 = 1'b0;
  logic [7:0] s0;
  logic [1:0] s1;
  logic       cy0, v0, er0, bz0, cy1, v1, er1, bz1;

  addsub_btn_unit #(.WIDTH(8), .DB_CYCLES(4)) u0 (
    .clk(clk), .rst_n(rst_n), .A(a0), .B(b0), .Cin(cin), .btn1(btn1), .btn2(btn2),
    .S(s0), .C0(cy0), .valid(v0), .err(er0), .busy(bz0));

  addsub_btn_unit #(.WIDTH(2), .DB_CYCLES(1)) u1 (
    .clk(clk), .rst_n(rst_n), .A(a1), .B(b1), .Cin(cin), .btn1(btn1), .btn2(btn2),
    .S(s1), .C0(cy1), .valid(v1), .err(er1), .busy(bz1));

  always #5 clk = ~clk;

  int ncmp = 0, nfail = 0, ecnt = 0;
  bit chk_on = 1'b0;
  int vc[2], fv[2];
  int e_mark;

  always @(posedge clk) ecnt++;

  // Reference model: raw/sync histories as bit masks, debounced level flips once the
  // last DB synced samples all disagree with it; mode 0=ready, 1=result cycle, 2=waiting release.
  int wid[2] = '{8, 2};
  int dbn[2] = '{4, 1};
  int rh1[2], rh2[2], sh1[2], sh2[2];
  int m_db1[2], m_db2[2], m_dbp1[2], m_dbp2[2];
  int mode[2], blk[2], nedge[2];
  int eS[2], eC[2], ev[2], eerr[2];

  task automatic model_reset(input int k);
    rh1[k] = 0; rh2[k] = 0; sh1[k] = 0; sh2[k] = 0;
    m_db1[k] = 0; m_db2[k] = 0; m_dbp1[k] = 0; m_dbp2[k] = 0;
    mode[k] = 0; blk[k] = 0; nedge[k] = 0;
    eS[k] = 0; eC[k] = 0; ev[k] = 0; eerr[k] = 0;
  endtask

  task automatic model_step(input int k, input int a, input int b);
    int y1, y2, p1, p2, mask, nd1, nd2, od1, od2, nblk, md, tot;
    nedge[k]++;
    y1 = (rh1[k] >> 1) & 1;
    y2 = (rh2[k] >> 1) & 1;
    rh1[k] = ((rh1[k] << 1) | int'(btn1)) & 3;
    rh2[k] = ((rh2[k] << 1) | int'(btn2)) & 3;
    sh1[k] = ((sh1[k] << 1) | y1) & 16'hFFFF;
    sh2[k] = ((sh2[k] << 1) | y2) & 16'hFFFF;
    mask = (1 << dbn[k]) - 1;
    od1 = m_db1[k]; od2 = m_db2[k];
    nd1 = od1; nd2 = od2;
    if (od1 == 0 && (sh1[k] & mask) == mask) nd1 = 1;
    if (od1 == 1 && (sh1[k] & mask) == 0)    nd1 = 0;
    if (od2 == 0 && (sh2[k] & mask) == mask) nd2 = 1;
    if (od2 == 1 && (sh2[k] & mask) == 0)    nd2 = 0;
    p1 = od1 & ~m_dbp1[k] & 1;
    p2 = od2 & ~m_dbp2[k] & 1;
    m_dbp1[k] = od1; m_dbp2[k] = od2;
    m_db1[k] = nd1; m_db2[k] = nd2;
    nblk = blk[k];
    if (nedge[k] == 3 && (y1 | y2) != 0) nblk = 1;
    else if (y1 == 0 && y2 == 0)         nblk = 0;
    ev[k] = 0;
    md = 1 << wid[k];
    case (mode[k])
      0: begin
        if (nedge[k] == 3 && (y1 | y2) != 0) mode[k] = 2;
        else if (p1 != 0 && p2 != 0) begin eerr[k] = 1; mode[k] = 2; end
        else if (p1 != 0) begin
          tot = a + b + int'(cin);
          eS[k] = tot % md; eC[k] = (tot >= md) ? 1 : 0;
          ev[k] = 1; eerr[k] = 0; mode[k] = 1;
        end else if (p2 != 0) begin
          eS[k] = (a - b - int'(cin) + 2 * md) % md;
          eC[k] = (a < b + int'(cin)) ? 1 : 0;
          ev[k] = 1; eerr[k] = 0; mode[k] = 1;
        end
      end
      1: mode[k] = 2;
      default: if (od1 == 0 && od2 == 0 && blk[k] == 0) mode[k] = 0;
    endcase
    blk[k] = nblk;
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      model_reset(0);
      model_reset(1);
    end else begin
      model_step(0, int'(a0), int'(b0));
      model_step(1, int'(a1), int'(b1));
    end
  end

  task automatic cmp_out(input int k, input int gs, input int gc, input int gv, input int ge, input int gb);
    int xb;
    xb = (mode[k] != 0) ? 1 : 0;
    ncmp++;
    if (gs != eS[k] || gc != eC[k] || gv != ev[k] || ge != eerr[k] || gb != xb) begin
      nfail++;
      $display("FAIL outputs inst%0d edge %0d: got S=%0d C0=%0d valid=%0d err=%0d busy=%0d, expected S=%0d C0=%0d valid=%0d err=%0d busy=%0d",
               k, ecnt, gs, gc, gv, ge, gb, eS[k], eC[k], ev[k], eerr[k], xb);
    end
  endtask

  always @(negedge clk) begin
    #1;
    if (chk_on) begin
      cmp_out(0, int'(s0), int'(cy0), int'(v0), int'(er0), int'(bz0));
      cmp_out(1, int'(s1), int'(cy1), int'(v1), int'(er1), int'(bz1));
    end
    if (v0) begin vc[0]++; if (fv[0] < 0) fv[0] = ecnt; end
    if (v1) begin vc[1]++; if (fv[1] < 0) fv[1] = ecnt; end
  end

  task automatic chk(input string nm, input int got, input int exp);
    ncmp++;
    if (got != exp) begin
      nfail++;
      $display("FAIL %s: got %0d expected %0d", nm, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic mark();
    vc[0] = 0; vc[1] = 0; fv[0] = -1; fv[1] = -1;
    e_mark = ecnt;
  endtask

  initial begin
    mark();
    #1 rst_n = 1'b0;
    #1 chk_on = 1'b1;
    chk("reset_S", int'(s0), 0);
    chk("reset_busy", int'(bz0), 0);
    cyc(2);
    rst_n = 1'b1;
    cyc(4);

    // Add with overflow on both widths
    a0 = 8'd200; b0 = 8'd100; a1 = 2'd3; b1 = 2'd3; cin = 1'b1;
    cyc(1);
    mark();
    btn1 = 1'b1;
    cyc(20);
    chk("add_latency_w8", fv[0] - e_mark, 7);
    chk("add_latency_w2", fv[1] - e_mark, 4);
    chk("add_pulses_w8", vc[0], 1);
    chk("add_S_w8", int'(s0), 45);
    chk("add_C0_w8", int'(cy0), 1);
    chk("add_S_w2", int'(s1), 3);
    chk("add_C0_w2", int'(cy1), 1);
    btn1 = 1'b0;
    cyc(10);
    chk("add_hold_S", int'(s0), 45);
    chk("add_hold_C0", int'(cy0), 1);
    chk("add_idle_busy", int'(bz0), 0);

    // Asynchronous reset mid-run, checked before any clock edge
    a0 = 8'd77; btn1 = 1'b1; btn2 = 1'b1;
    cyc(3);
    rst_n = 1'b0;
    #2;
    chk("async_rst_S", int'(s0), 0);
    chk("async_rst_C0", int'(cy0), 0);
    chk("async_rst_valid", int'(v0), 0);
    chk("async_rst_err", int'(er0), 0);
    chk("async_rst_busy", int'(bz0), 0);
    chk("async_rst_S_w2", int'(s1), 0);
    btn1 = 1'b0; btn2 = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    cyc(4);

    // Subtract with and without borrow
    a0 = 8'd5; b0 = 8'd7; cin = 1'b0; a1 = 2'd1; b1 = 2'd2;
    mark();
    btn2 = 1'b1; cyc(12); btn2 = 1'b0; cyc(10);
    chk("sub1_S", int'(s0), 254);
    chk("sub1_C0", int'(cy0), 1);
    chk("sub1_pulses", vc[0], 1);
    a0 = 8'd7; b0 = 8'd5; cin = 1'b1;
    mark();
    btn2 = 1'b1; cyc(12); btn2 = 1'b0; cyc(10);
    chk("sub2_S", int'(s0), 1);
    chk("sub2_C0", int'(cy0), 0);
    chk("sub2_pulses", vc[0], 1);

    // Bounce: 2-cycle glitches never survive the 4-cycle filter
    a0 = 8'd10; b0 = 8'd20; cin = 1'b0;
    mark();
    for (int i = 0; i < 15; i++) begin
      if (i == 14) begin
        chk("bounce_no_valid", vc[0], 0);
        mark();
      end
      btn1 = (i % 2 == 0) ? 1'b1 : 1'b0;
      cyc(2);
    end
    cyc(13);
    chk("bounce_latency", fv[0] - e_mark, 7);
    chk("bounce_pulses", vc[0], 1);
    btn1 = 1'b0;
    cyc(10);
    chk("bounce_S", int'(s0), 30);

    // Simultaneous press, ignored press while held, recovery
    mark();
    btn1 = 1'b1; btn2 = 1'b1;
    cyc(12);
    chk("both_err", int'(er0), 1);
    chk("both_err_w2", int'(er1), 1);
    chk("both_no_valid", vc[0], 0);
    chk("both_S_kept", int'(s0), 30);
    btn1 = 1'b0; cyc(10); btn1 = 1'b1; cyc(12);
    chk("held_other_ignored", vc[0], 0);
    chk("held_err_sticky", int'(er0), 1);
    btn1 = 1'b0; btn2 = 1'b0; cyc(12);
    a0 = 8'd1; b0 = 8'd2;
    mark();
    btn1 = 1'b1; cyc(12);
    chk("recover_pulses", vc[0], 1);
    chk("recover_err", int'(er0), 0);
    chk("recover_S", int'(s0), 3);
    btn1 = 1'b0; cyc(10);

    // Reset while a button is held: must be released and re-pressed
    btn1 = 1'b1; cyc(12);
    rst_n = 1'b0; cyc(2); rst_n = 1'b1;
    mark();
    cyc(20);
    chk("held_rst_no_valid", vc[0], 0);
    chk("held_rst_no_valid_w2", vc[1], 0);
    chk("held_rst_busy", int'(bz0), 1);
    btn1 = 1'b0; cyc(10);
    a0 = 8'd9; b0 = 8'd9; cin = 1'b0;
    mark();
    btn1 = 1'b1; cyc(12);
    chk("repress_pulses", vc[0], 1);
    chk("repress_S", int'(s0), 18);
    btn1 = 1'b0; cyc(10);

    // Randomised buttons, operands and occasional resets
    for (int n = 0; n < 300; n++) begin
      int r;
      r = $urandom_range(0, 99);
      if (r < 3) begin
        rst_n = 1'b0; cyc(1); rst_n = 1'b1;
      end else begin
        r = $urandom_range(0, 5);
        btn1 = (r == 1 || r == 3) ? 1'b1 : 1'b0;
        btn2 = (r == 2 || r == 3) ? 1'b1 : 1'b0;
        a0 = 8'($urandom); b0 = 8'($urandom);
        a1 = 2'($urandom); b1 = 2'($urandom);
        cin = 1'($urandom);
        cyc($urandom_range(1, 10));
      end
    end
    btn1 = 1'b0; btn2 = 1'b0;
    cyc(20);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end
endmodule

// File: doc/addsub_btn_unit.md
Name: addsub_btn_unit

Overview:
Parametrised, clocked successor to the team's button-selected 2-bit adder/subtractor. Two push-buttons are synchronised and debounced. A clean press of btn1 executes one WIDTH-bit add; a clean press of btn2 executes one subtract. The result is registered and held, and a one-cycle valid pulse marks each update. The block sits between the board switches/buttons and the LED/7-seg display logic.

Parameters:
WIDTH, 8, operand/result width in bits (>=2).
DB_CYCLES, 4, consecutive stable cycles required before a debounced button level changes (>=1).

Ports:
clk  input  1  system clock, all logic on rising edge
rst_n  input  1  asynchronous active-low reset
A  input  WIDTH  operand A (static switches, sampled at execute)
B  input  WIDTH  operand B (static switches, sampled at execute)
Cin  input  1  carry-in (add) / borrow-in (subtract)
btn1  input  1  raw add button, active-high, asynchronous, bouncy
btn2  input  1  raw subtract button, active-high, asynchronous, bouncy
S  output  WIDTH  registered result
C0  output  1  registered carry-out (add) / borrow-out (subtract)
valid  output  1  one-cycle pulse, S/C0 updated this cycle
err  output  1  sticky: both buttons pressed in the same cycle
busy  output  1  high while FSM is not IDLE

Behaviour:
- Reset (async, rst_n=0): S=0, C0=0, valid=0, err=0, busy=0, FSM=IDLE. Synchroniser flops, debounced levels, edge-detect flops and counters all cleared to 0.
- Reset release mid-bounce or while a button is held: no operation fires until the button is seen released and pressed again.
  - The debounced level starts at 0, so a button already held produces a rising edge after DB_CYCLES.
  - FSM starts in IDLE but must not act on it. On reset exit the FSM enters HOLD if either synchronised raw button is 1.
- Synchroniser: 2 flops per button.
- Debounce: per-button counter, width ceil(log2(DB_CYCLES+1)).
  - Counter clears whenever sync == debounced level.
  - Otherwise it increments. When it reaches DB_CYCLES the debounced level toggles and the counter clears.
- Edge pulse: press1 = db1 & ~db1_q, where db1_q is db1 delayed one cycle; press2 likewise.
- FSM states: IDLE, EXEC, HOLD.
  - IDLE, press1 & ~press2: latch op=ADD, go EXEC.
  - IDLE, press2 & ~press1: latch op=SUB, go EXEC.
  - IDLE, press1 & press2: err<=1, go HOLD, S/C0 unchanged.
  - EXEC: sample A, B, Cin; register result; valid<=1 for exactly this one cycle; clear err; go HOLD.
  - HOLD: wait until db1==0 and db2==0, then go IDLE. Presses of either button in HOLD are ignored, including pressing the other button while one is held.
- busy = (state != IDLE).
- Latency: valid is high in the cycle after the press pulse. From the first clk edge at which raw btn is sampled stable high, valid asserts on edge 2+DB_CYCLES+1 (=7 at default).
- Add: {C0,S} = A + B + Cin, computed at WIDTH+1 bits.
- Subtract: {C0,S} = {1'b0,A} - {1'b0,B} - Cin, at WIDTH+1 bits. S = low WIDTH bits (two's-complement wrap). C0 = 1 iff A < B + Cin (borrow).
- Between operations S and C0 hold their last value. Releasing the buttons does not zero them.
- Only reset clears S and C0.
- err stays set until the next successful EXEC or reset.

Test Plan:
1. Reset: assert rst_n=0 mid-run with arbitrary inputs -> S=0, C0=0, valid=0, err=0, busy=0 immediately, with no clock required.
2. Add with overflow: A=200, B=100, Cin=1, clean btn1 press held 20 cycles -> single valid pulse on edge 7, S=45, C0=1; S/C0 persist after release.
3. Subtract: A=5, B=7, Cin=0, btn2 -> S=254, C0=1. Then A=7, B=5, Cin=1, btn2 -> S=1, C0=0. Exactly one valid pulse per press.
4. Bounce: btn1 toggles every 2 cycles for 30 cycles, then held -> no valid during bouncing. Exactly one valid, DB_CYCLES+3 edges after the last low-to-high transition.
5. Simultaneous press: btn1 and btn2 asserted the same cycle -> err=1, no valid, S/C0 unchanged. Hold btn2, then press btn1 -> ignored. Release both, press btn1 -> valid, err=0.
6. Reset during hold: btn1 held, pulse rst_n low, btn1 still held -> no valid until btn1 released and re-pressed. Repeat tests 2 and 5 with WIDTH=2, DB_CYCLES=1: A=3, B=3, Cin=1 add -> S=3, C0=1.
